// File: rtl/blink_mode_ctrl_pkg.sv
// Shared definitions for the blink-rate front end and the LED blinker:
// rate encodings, the default debounce length and the rate-step helper.
package blink_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_1HZ  = 2'b00,
        MODE_5HZ  = 2'b01,
        MODE_10HZ = 2'b10,
        MODE_20HZ = 2'b11
    } rate_t;

    // 10 ms of stable level at 50 MHz
    localparam int C_DEBOUNCE_COUNT_DEFAULT = 500_000;

    // Next rate in the cycle 1 Hz -> 5 Hz -> 10 Hz -> 20 Hz -> 1 Hz
    function automatic rate_t next_rate(input rate_t cur);
        return rate_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/blink_mode_ctrl_debounce.sv
// One push-button path: optional inversion, 2-flop synchroniser,
// counter-based debouncer and rising-edge press detector.
import blink_mode_ctrl_pkg::*;

module button_debounce #(
    parameter int c_debounce_count = C_DEBOUNCE_COUNT_DEFAULT,
    parameter bit c_btn_active_low = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam logic [31:0] c_last = 32'(c_debounce_count - 1);

    logic        btn_p0;
    logic        sync_p1;
    logic        sync_p2;
    logic [31:0] cnt;
    logic        stable;
    logic        stable_d;

    // Inversion happens before the synchroniser so everything downstream
    // sees "1 = pressed".
    assign btn_p0 = c_btn_active_low ? ~i_btn : i_btn;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p1 <= btn_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Accept a new level only after it has differed from the stable level
    // for c_debounce_count consecutive cycles; any bounce restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= 32'd0;
            stable <= 1'b0;
        end else if (sync_p2 == stable) begin
            cnt <= 32'd0;
        end else if (cnt == c_last) begin
            stable <= sync_p2;
            cnt    <= 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // Delayed copy of the stable level for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign o_level = stable;
    // Driven only from flops, so no combinational path from i_btn
    assign o_press = stable & ~stable_d;

endmodule

// File: rtl/blink_mode_ctrl.sv
// Blinker front end: turns two debounced buttons into the blinker's
// rate-select (cycling) and enable (toggling) inputs.
import blink_mode_ctrl_pkg::*;

module blink_mode_ctrl #(
    parameter int c_debounce_count = C_DEBOUNCE_COUNT_DEFAULT,
    parameter bit c_btn_active_low = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_mode,
    input  logic i_btn_enable,
    output logic o_select0,
    output logic o_select1,
    output logic o_enable
);

    rate_t mode_q;
    logic  enable_q;
    logic  mode_press;
    logic  enable_press;
    logic  mode_level_unused;
    logic  enable_level_unused;

    button_debounce #(
        .c_debounce_count (c_debounce_count),
        .c_btn_active_low (c_btn_active_low)
    ) u_mode_btn (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_mode),
        .o_level (mode_level_unused),
        .o_press (mode_press)
    );

    button_debounce #(
        .c_debounce_count (c_debounce_count),
        .c_btn_active_low (c_btn_active_low)
    ) u_enable_btn (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_enable),
        .o_level (enable_level_unused),
        .o_press (enable_press)
    );

    // Rate register steps on each mode press and enable toggles on each
    // enable press; the two are independent and may update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q   <= MODE_1HZ;
            enable_q <= 1'b1;
        end else begin
            if (mode_press) begin
                mode_q <= next_rate(mode_q);
            end
            if (enable_press) begin
                enable_q <= ~enable_q;
            end
        end
    end

    assign o_select0 = mode_q[0];
    assign o_select1 = mode_q[1];
    assign o_enable  = enable_q;

endmodule
